// File: rtl/out_ram_reader_if.sv
// AXI-Stream bundle from out_ram_reader toward DMA.
// master: tdata/tkeep/tvalid/tlast out, tready in; slave: the reverse.
interface out_ram_reader_if #(
    parameter int OUT_BITS = 32
);
    logic [OUT_BITS-1:0]   tdata;
    logic [OUT_BITS/8-1:0] tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata, tkeep, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/out_ram_reader.sv
// Drains one output-RAM bank through the read port into an AXI-Stream master.
// Ports: aclk/aresetn, cfg_words, ram_addr_a/ram_en_a/ram_rddata_a,
// done_fill in, t_done_proc pulse out, m_axis (out_ram_reader_if.master).
// Optional OUT_READER_STALL_CNT_EN adds stall_cycles (tvalid && !tready count).
module out_ram_reader #(
    parameter int OUT_ADDR_WIDTH = 10,
    parameter int OUT_BITS       = 32,
    parameter int RAM_LATENCY    = 2,
    parameter int FIFO_DEPTH     = RAM_LATENCY + 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [OUT_ADDR_WIDTH:0]   cfg_words,
    output logic [OUT_ADDR_WIDTH+1:0] ram_addr_a,
    output logic                      ram_en_a,
    input  logic [OUT_BITS-1:0]       ram_rddata_a,
    input  logic                      done_fill,
    output logic                      t_done_proc,
    out_ram_reader_if.master          m_axis
`ifdef OUT_READER_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    localparam int AW1 = OUT_ADDR_WIDTH + 1;
    localparam int PW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]             state;
    logic [AW1-1:0]         n_words;
    logic [AW1-1:0]         issue_idx;
    logic [AW1-1:0]         out_idx;
    logic [RAM_LATENCY-1:0] sr;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          fifo_count;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [OUT_BITS-1:0]    mem [FIFO_DEPTH];
    logic                   can_issue;
    logic                   push;
    logic                   pop;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            inflight = inflight + CW'(sr[i]);
        end
    end

    // Credit: words already queued plus words still in the RAM pipe
    // must leave room, so a returning read always finds a free slot.
    assign can_issue = (issue_idx < n_words) &&
                       ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

    assign ram_en_a   = (state == S_READ) && can_issue;
    assign ram_addr_a = ram_en_a ?
                        {issue_idx[OUT_ADDR_WIDTH-1:0], 2'b00} : '0;

    assign push = sr[RAM_LATENCY-1];
    assign pop  = m_axis.tvalid && m_axis.tready;

    assign t_done_proc   = (state == S_DONE);
    assign m_axis.tvalid = (fifo_count != '0);
    assign m_axis.tdata  = m_axis.tvalid ? mem[rd_ptr] : '0;
    assign m_axis.tkeep  = '1;
    assign m_axis.tlast  = m_axis.tvalid &&
                           (out_idx == n_words - AW1'(1));

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= ram_rddata_a;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sr         <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            sr <= RAM_LATENCY'({sr, ram_en_a});
            if (push) begin
                wr_ptr <= ptr_nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_nxt(rd_ptr);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            n_words   <= '0;
            issue_idx <= '0;
            out_idx   <= '0;
        end else begin
            if (pop) begin
                out_idx <= out_idx + AW1'(1);
            end
            case (state)
                S_IDLE: begin
                    if (done_fill) begin
                        n_words   <= cfg_words;
                        issue_idx <= '0;
                        out_idx   <= '0;
                        state     <= (cfg_words == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (ram_en_a) begin
                        issue_idx <= issue_idx + AW1'(1);
                        if (issue_idx + AW1'(1) == n_words) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (inflight == '0 && fifo_count == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_HOLD;
                S_HOLD:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef OUT_READER_STALL_CNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cycles <= '0;
        end else if (state == S_IDLE && done_fill) begin
            stall_cycles <= '0;
        end else if (m_axis.tvalid && !m_axis.tready &&
                     stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
